md_unit: RTL

//  E-stage multiply/divide unit with HI/LO registers. Consumes the forwarded RS/RT

---
 rtl/md_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/md_unit.sv
// E-stage multiply/divide unit with HI/LO registers and a multi-cycle busy model.
// Operands are latched at start; the result is written to HI/LO on the final RUN edge.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic [31:0]   a_q, b_q;
    logic          is_muldiv;

    assign is_muldiv = start && (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign busy      = is_muldiv || (state == RUN);
    assign md_out    = hilo_sel ? hi : lo;

    // Signed ops use sign-extended operands; the low 64 bits of the product are exact.
    logic        sgn;
    logic [63:0] ext_a, ext_b, prod;
    assign sgn   = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign ext_a = {{32{sgn & a_q[31]}}, a_q};
    assign ext_b = {{32{sgn & b_q[31]}}, b_q};
    assign prod  = ext_a * ext_b;

    // Divide on magnitudes so 0x80000000 / -1 needs no special case.
    logic [31:0] mag_a, mag_b, den, uq, ur, quo, rem;
    logic        neg_q, neg_r;
    assign mag_a = (sgn && a_q[31]) ? (~a_q + 32'd1) : a_q;
    assign mag_b = (sgn && b_q[31]) ? (~b_q + 32'd1) : b_q;
    assign den   = (b_q == 32'd0) ? 32'd1 : mag_b;
    assign uq    = mag_a / den;
    assign ur    = mag_a % den;
    assign neg_q = sgn && (a_q[31] ^ b_q[31]);
    assign neg_r = sgn && a_q[31];
    assign quo   = neg_q ? (~uq + 32'd1) : uq;
    assign rem   = neg_r ? (~ur + 32'd1) : ur;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_muldiv) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= md_op;
                        cnt   <= (md_op <= OP_MULTU) ? CW'(MULT_CYCLES - 1)
                                                     : CW'(DIV_CYCLES - 1);
                        state <= RUN;
                    end else if (start && md_op == OP_MTHI) begin
                        hi <= a;
                    end else if (start && md_op == OP_MTLO) begin
                        lo <= a;
                    end
                end
                RUN: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        if (op_q == OP_MULT || op_q == OP_MULTU) begin
                            hi <= prod[63:32];
                            lo <= prod[31:0];
                        end else if (b_q != 32'd0) begin
                            hi <= rem;
                            lo <= quo;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
